// File: rtl/countdown_timer.sv
// Seconds countdown timer: binary count 0..MAX_VALUE, decremented once per TICKS_PER_SEC clocks while running.
// Latency: all outputs registered; first decrement lands TICKS_PER_SEC cycles after the start pulse is sampled.
// Backpressure: none; control inputs are single-cycle pulses, priority load > pause > start > tick.
module countdown_timer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int MAX_VALUE     = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] count_value,
   output logic       running,
   output logic       expired
);

   // Prescaler only needs to reach TICKS_PER_SEC-1; keep at least one bit.
   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]    MAX_CNT   = 8'(MAX_VALUE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic [7:0]    load_clamped;

   // Out-of-range load values saturate so the two-digit display stays valid.
   always_comb begin
      load_clamped = (load_value > MAX_CNT) ? MAX_CNT : load_value;
   end

   // Control FSM, prescaler and count; running/expired are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count_value <= 8'd0;
         prescaler   <= '0;
         running     <= 1'b0;
         expired     <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (load) begin
            count_value <= load_clamped;
            prescaler   <= '0;
            state       <= IDLE;
            running     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // A zero count cannot run, otherwise it would expire without a decrement.
                  if (!pause && start && (count_value != 8'd0)) begin
                     prescaler <= '0;
                     state     <= RUN;
                     running   <= 1'b1;
                  end
               end
               RUN: begin
                  if (pause) begin
                     // Prescaler is left as-is so the partial second survives the pause.
                     state   <= PAUSED;
                     running <= 1'b0;
                  end else if (prescaler == TICK_LAST) begin
                     prescaler   <= '0;
                     count_value <= count_value - 8'd1;
                     if (count_value == 8'd1) begin
                        state   <= DONE;
                        running <= 1'b0;
                        expired <= 1'b1;
                     end
                  end else begin
                     prescaler <= prescaler + 1'b1;
                  end
               end
               PAUSED: begin
                  if (!pause && start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               DONE: begin
                  // Terminal: only load or reset leaves here.
                  state <= DONE;
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

   localparam int T    = 4;
   localparam int MAXV = 99;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] load_value;
   logic       start;
   logic       pause;
   logic [7:0] count_value;
   logic       running;
   logic       expired;

   always #5 clk = ~clk;

   countdown_timer #(.TICKS_PER_SEC(T), .MAX_VALUE(MAXV)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .pause      (pause),
      .count_value(count_value),
      .running    (running),
      .expired    (expired)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit ld, input logic [7:0] lv, input bit st, input bit pa);
      load       = ld;
      load_value = lv;
      start      = st;
      pause      = pa;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int c, input bit r, input bit e);
      check({tag, ".count"}, 32'(count_value), 32'(c));
      check({tag, ".running"}, 32'(running), 32'(r));
      check({tag, ".expired"}, 32'(expired), 32'(e));
   endtask

   // Reference model: count is the loaded value minus whole seconds of accumulated run time.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   int m_loaded, m_run_cycles, m_mode;
   bit m_exp;

   function automatic int m_count();
      return m_loaded - (m_run_cycles / T);
   endfunction

   task automatic model_reset();
      m_loaded = 0; m_run_cycles = 0; m_mode = M_IDLE; m_exp = 0;
   endtask

   task automatic model_edge(input bit ld, input int lv, input bit st, input bit pa);
      m_exp = 0;
      if (ld) begin
         m_loaded = (lv > MAXV) ? MAXV : lv;
         m_run_cycles = 0;
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         if (!pa && st && m_count() != 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (pa) m_mode = M_PAUSED;
         else begin
            m_run_cycles++;
            if (m_count() == 0) begin
               m_mode = M_DONE;
               m_exp = 1;
            end
         end
      end else if (m_mode == M_PAUSED) begin
         if (!pa && st) m_mode = M_RUN;
      end
   endtask

   typedef struct {
      bit         ld;
      logic [7:0] lv;
      bit         st;
      bit         pa;
      int         c;
      bit         r;
      bit         e;
   } vec_t;

   vec_t tbl[25];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Countdown 3->0, then DONE ignores start; clamp; load+start; pause+start in RUN; zero start.
      tbl[0]  = '{1'b1, 8'd3,   1'b0, 1'b0, 3,  1'b0, 1'b0};
      tbl[1]  = '{1'b0, 8'd0,   1'b1, 1'b0, 3,  1'b1, 1'b0};
      tbl[2]  = '{1'b0, 8'd0,   1'b0, 1'b0, 3,  1'b1, 1'b0};
      tbl[3]  = '{1'b0, 8'd0,   1'b1, 1'b0, 3,  1'b1, 1'b0};
      tbl[4]  = '{1'b0, 8'd0,   1'b0, 1'b0, 3,  1'b1, 1'b0};
      tbl[5]  = '{1'b0, 8'd0,   1'b0, 1'b0, 2,  1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'd0,   1'b0, 1'b0, 2,  1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'd0,   1'b0, 1'b0, 2,  1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'd0,   1'b0, 1'b0, 2,  1'b1, 1'b0};
      tbl[9]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1,  1'b1, 1'b0};
      tbl[10] = '{1'b0, 8'd0,   1'b0, 1'b0, 1,  1'b1, 1'b0};
      tbl[11] = '{1'b0, 8'd0,   1'b0, 1'b0, 1,  1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'd0,   1'b0, 1'b0, 1,  1'b1, 1'b0};
      tbl[13] = '{1'b0, 8'd0,   1'b0, 1'b0, 0,  1'b0, 1'b1};
      tbl[14] = '{1'b0, 8'd0,   1'b1, 1'b0, 0,  1'b0, 1'b0};
      tbl[15] = '{1'b0, 8'd0,   1'b0, 1'b1, 0,  1'b0, 1'b0};
      tbl[16] = '{1'b1, 8'd200, 1'b0, 1'b0, 99, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 8'd10,  1'b1, 1'b0, 10, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 8'd0,   1'b0, 1'b0, 10, 1'b0, 1'b0};
      tbl[19] = '{1'b0, 8'd0,   1'b1, 1'b0, 10, 1'b1, 1'b0};
      tbl[20] = '{1'b0, 8'd0,   1'b1, 1'b1, 10, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 8'd0,   1'b1, 1'b0, 10, 1'b1, 1'b0};
      tbl[22] = '{1'b1, 8'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0};
      tbl[23] = '{1'b0, 8'd0,   1'b1, 1'b0, 0,  1'b0, 1'b0};
      tbl[24] = '{1'b0, 8'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0};

      reset = 1'b1;
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      #12;
      check_out("reset", 0, 1'b0, 1'b0);
      reset = 1'b0;
      step();

      // Idle hold after load 12
      drive(1'b1, 8'd12, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      check_out("load12", 12, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_hold.count", 32'(count_value), 32'd12);
         check("idle_hold.running", 32'(running), 32'd0);
      end

      // Table-driven vectors
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa);
         step();
         drive(1'b0, 8'd0, 1'b0, 1'b0);
         check_out($sformatf("vec%0d", i), tbl[i].c, tbl[i].r, tbl[i].e);
      end

      // Pause partway through a second, hold, then resume with the partial second preserved
      drive(1'b1, 8'd5, 1'b0, 1'b0); step();
      drive(1'b0, 8'd0, 1'b1, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0, 1'b0); step(); step();
      drive(1'b0, 8'd0, 1'b0, 1'b1); step();
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      check_out("pause", 5, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         check_out("pause_hold", 5, 1'b0, 1'b0);
      end
      drive(1'b0, 8'd0, 1'b1, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0, 1'b0);
      check_out("resume0", 5, 1'b1, 1'b0);
      step();
      check_out("resume1", 5, 1'b1, 1'b0);
      step();
      check_out("resume2", 4, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a run at count 7
      drive(1'b1, 8'd7, 1'b0, 1'b0); step();
      drive(1'b0, 8'd0, 1'b1, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0, 1'b0); step(); step();
      check_out("pre_reset", 7, 1'b1, 1'b0);
      #3 reset = 1'b1;
      #1;
      check_out("async_reset", 0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      step();
      check_out("post_reset", 0, 1'b0, 1'b0);

      // Randomized run against the reference model
      model_reset();
      for (int i = 0; i < 2000; i++) begin
         bit ld, st, pa;
         int lv;
         ld = ($urandom_range(0, 59) == 0);
         lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
         st = ($urandom_range(0, 5) == 0);
         pa = ($urandom_range(0, 9) == 0);
         if (st && pa) st = 1'b0;
         drive(ld, 8'(lv), st, pa);
         model_edge(ld, lv, st, pa);
         step();
         drive(1'b0, 8'd0, 1'b0, 1'b0);
         check_out("rand", m_count(), (m_mode == M_RUN), m_exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Seconds countdown timer feeding the two-digit decimal seven-segment display stage.
- Holds a binary count in the range 0..MAX_VALUE and decrements it once per TICKS_PER_SEC clocks while running.
- Drives count_value[7:0] straight into the display stage's 8-bit dec_number input.
- Provides start/pause/load control and a one-cycle expiry pulse for game/control logic.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second decrement (must be >= 2).
- MAX_VALUE, 99, largest loadable count; keeps the two-digit display valid.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  single-cycle pulse; loads load_value.
- load_value  input  8  start value in binary; values above MAX_VALUE are clamped.
- start  input  1  single-cycle pulse; begins or resumes counting.
- pause  input  1  single-cycle pulse; freezes counting.
- count_value  output  8  current count in binary, 0..MAX_VALUE; connects to the display stage.
- running  output  1  high while in RUN.
- expired  output  1  one-cycle pulse when the count reaches 0 by decrement.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, count_value = 0, prescaler = 0, running = 0, expired = 0.
  - All outputs come from registers.
- State machine:
  - States: IDLE, RUN, PAUSED, DONE.
  - running = (state == RUN), registered in the same edge as the state update.
- Priority per cycle: load > pause > start > prescaler tick.
- load (any state):
  - count_value <= min(load_value, MAX_VALUE); prescaler <= 0; state <= IDLE; expired <= 0.
  - Any simultaneous start/pause in that cycle is ignored.
- IDLE:
  - start with count_value != 0: prescaler <= 0, go to RUN.
  - start with count_value == 0: ignored, stay IDLE, no expired pulse.
  - pause: ignored.
- RUN:
  - Each cycle, prescaler increments.
  - When prescaler == TICKS_PER_SEC-1: prescaler <= 0 and count_value <= count_value-1.
  - If that decrement takes count_value from 1 to 0: state <= DONE and expired <= 1 on the same edge, so expired is high exactly during the first cycle count_value reads 0.
  - The first decrement lands TICKS_PER_SEC cycles after the start pulse is sampled.
  - pause: go to PAUSED, prescaler holds its value (partial second preserved). pause wins over start; a tick coincident with pause is not applied.
  - start: ignored.
- PAUSED:
  - count_value and prescaler are held.
  - start: resume RUN from the held prescaler.
  - pause: ignored.
- DONE:
  - count_value stays 0.
  - start and pause are ignored; only load or reset leaves DONE.
- expired is 0 in every cycle except the single terminal-decrement cycle.
- Arithmetic and widths:
  - count_value never wraps below 0 or exceeds MAX_VALUE.
  - Prescaler width is clog2(TICKS_PER_SEC).
  - Clamp compare is 8-bit unsigned.
- Reset mid-operation (any state, any prescaler phase) returns immediately to the reset values above, with no expired pulse.

Test Plan:
- Reset, then load_value=12, load; then check idle hold: count_value=12, running=0; holds 12 for 20 cycles with no start.
- Countdown (TICKS_PER_SEC=4): load 3, start → count_value 3→2→1→0 at 4-cycle intervals after start. expired=1 for exactly one cycle, coincident with the first 0. State DONE, running=0, and a later start leaves count at 0.
- Pause/resume (TICKS_PER_SEC=4): load 5, start; pause 2 cycles into the second → count holds 5 for 10 cycles. Then start → decrement to 4 exactly 2 cycles after resume.
- Clamp and priority:
  - load_value=200 with load → count_value=99.
  - load and start in the same cycle → IDLE, running=0.
  - pause and start together in RUN → PAUSED.
- Zero and reset edge cases:
  - load 0, start → stays IDLE, expired never asserts.
  - Reset asserted mid-RUN at count 7 → count_value=0, running=0, expired=0 asynchronously.
